// File: rtl/ehl_rv_skid_if.sv
// ehl_rv_skid_if: valid/ready bundle for the ehl_rv_skid slice.
// Ports: in_valid/in_ready/data_in upstream, out_valid/out_ready/data_out downstream, occupancy.
interface ehl_rv_skid_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data_out;
    logic [1:0]       occupancy;

    modport master (
        output in_valid, data_in, out_ready,
        input  in_ready, out_valid, data_out, occupancy
    );

    modport slave (
        input  in_valid, data_in, out_ready,
        output in_ready, out_valid, data_out, occupancy
    );
endinterface

// File: rtl/ehl_rv_skid.sv
// ehl_rv_skid: two-entry valid/ready skid slice, or pure bypass when ENA=0.
// Ports: clk, reset_n (async active-low), bus (slave side of ehl_rv_skid_if).
module ehl_rv_skid #(
    parameter bit ENA   = 1'b1,
    parameter int WIDTH = 8
) (
    input logic         clk,
    input logic         reset_n,
    ehl_rv_skid_if.slave bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    if (ENA) begin : g_slice
        state_e           state_q, state_d;
        logic             in_ready_q, in_ready_d;
        logic             out_valid_q, out_valid_d;
        logic [WIDTH-1:0] main_q, main_d;
        logic [WIDTH-1:0] skid_q, skid_d;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q     <= EMPTY;
                in_ready_q  <= 1'b1;
                out_valid_q <= 1'b0;
            end else begin
                state_q     <= state_d;
                in_ready_q  <= in_ready_d;
                out_valid_q <= out_valid_d;
            end
        end

        // Payload registers carry no reset; they only matter once valid.
        always_ff @(posedge clk) begin
            main_q <= main_d;
            skid_q <= skid_d;
        end

        always_comb begin
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;
            unique case (state_q)
                EMPTY: begin
                    if (bus.in_valid) begin
                        main_d  = bus.data_in;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (bus.in_valid && bus.out_ready) begin
                        main_d = bus.data_in;
                    end else if (bus.in_valid) begin
                        skid_d  = bus.data_in;
                        state_d = FULL;
                    end else if (bus.out_ready) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (bus.out_ready) begin
                        main_d  = skid_q;
                        state_d = BUSY;
                    end
                end
                default: state_d = EMPTY;
            endcase
            // Handshake outputs are precomputed so they leave straight from flops.
            in_ready_d  = (state_d != FULL);
            out_valid_d = (state_d != EMPTY);
        end

        assign bus.in_ready  = in_ready_q;
        assign bus.out_valid = out_valid_q;
        assign bus.data_out  = main_q;
        assign bus.occupancy = state_q;
    end else begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ reset_n;

        assign bus.out_valid = bus.in_valid;
        assign bus.data_out  = bus.data_in;
        assign bus.in_ready  = bus.out_ready;
        assign bus.occupancy = 2'd0;
    end

endmodule

// File: tb/tb_ehl_rv_skid.sv
// tb_ehl_rv_skid: table vectors, scoreboard and corner sequences for ehl_rv_skid.
// Covers registered slice (ENA=1) and bypass build (ENA=0).
module tb_ehl_rv_skid;

    logic clk;
    logic reset_n;

    ehl_rv_skid_if #(.WIDTH(8)) a ();
    ehl_rv_skid_if #(.WIDTH(8)) b ();

    ehl_rv_skid #(.ENA(1'b1), .WIDTH(8)) u_slice (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (a)
    );

    ehl_rv_skid #(.ENA(1'b0), .WIDTH(8)) u_bypass (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       ov;
        logic [7:0] dout;
        logic       ir;
        logic [1:0] occ;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] sb[$];
    int         checks;
    int         errors;
    logic       prev_stall;
    logic [7:0] prev_d;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic void add(input logic iv, input logic [7:0] d,
                                input logic ordy, input logic ov,
                                input logic [7:0] dout, input logic ir,
                                input logic [1:0] occ);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy;
        v.ov = ov; v.dout = dout; v.ir = ir; v.occ = occ;
        tbl.push_back(v);
    endfunction

    // Drive one cycle; sample 1ns after the falling edge, well before the
    // rising edge, and account handshakes on the scoreboard.
    task automatic step(input logic iv, input logic [7:0] d,
                        input logic ordy);
        logic [7:0] exp;
        @(negedge clk);
        a.in_valid  = iv;
        a.data_in   = d;
        a.out_ready = ordy;
        #1;
        if (prev_stall) begin
            chk("stall_valid", a.out_valid, 1'b1);
            chk("stall_data", a.data_out, prev_d);
        end
        prev_stall = a.out_valid && !a.out_ready;
        prev_d     = a.data_out;
        if (a.in_valid && a.in_ready) sb.push_back(a.data_in);
        if (a.out_valid && a.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual %0h required none",
                         a.data_out);
            end else begin
                exp = sb.pop_front();
                chk("sb_data", a.data_out, exp);
            end
        end
    endtask

    initial begin
        int         acc;
        int         cyc;
        logic [7:0] nxt;
        logic       iv;
        logic       ordy;
        logic [7:0] d;

        checks     = 0;
        errors     = 0;
        prev_stall = 1'b0;
        prev_d     = '0;
        a.in_valid = 1'b0; a.data_in = '0; a.out_ready = 1'b0;
        b.in_valid = 1'b0; b.data_in = '0; b.out_ready = 1'b0;
        reset_n    = 1'b0;

        // Reset-response walk-through, back-to-back stream, then skid fill.
        add(1, 8'h11, 1, 0, 8'h00, 1, 0);
        add(0, 8'h00, 1, 1, 8'h11, 1, 1);
        add(0, 8'h00, 1, 0, 8'h00, 1, 0);
        for (int i = 1; i <= 8; i++) begin
            add(1, 8'(i), 1, (i > 1), 8'(i - 1), 1, 2'((i > 1) ? 1 : 0));
        end
        add(0, 8'h00, 1, 1, 8'h08, 1, 1);
        add(0, 8'h00, 1, 0, 8'h00, 1, 0);
        add(1, 8'hA0, 0, 0, 8'h00, 1, 0);
        add(1, 8'hA1, 0, 1, 8'hA0, 1, 1);
        add(0, 8'h00, 0, 1, 8'hA0, 0, 2);
        add(0, 8'h00, 1, 1, 8'hA0, 0, 2);
        add(0, 8'h00, 1, 1, 8'hA1, 1, 1);
        add(0, 8'h00, 1, 0, 8'h00, 1, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", a.out_valid, 1'b0);
        chk("rst_in_ready", a.in_ready, 1'b1);
        chk("rst_occ", a.occupancy, 2'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].iv, tbl[i].d, tbl[i].ordy);
            chk($sformatf("v%0d_out_valid", i), a.out_valid, tbl[i].ov);
            chk($sformatf("v%0d_in_ready", i), a.in_ready, tbl[i].ir);
            chk($sformatf("v%0d_occ", i), a.occupancy, tbl[i].occ);
            if (tbl[i].ov)
                chk($sformatf("v%0d_data", i), a.data_out, tbl[i].dout);
        end
        chk("tbl_sb_empty", sb.size(), 0);

        // Reset pulse while two beats are held.
        step(1, 8'hB0, 0);
        step(1, 8'hB1, 0);
        step(0, 8'h00, 0);
        chk("full_occ", a.occupancy, 2'd2);
        chk("full_in_ready", a.in_ready, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("arst_out_valid", a.out_valid, 1'b0);
        chk("arst_in_ready", a.in_ready, 1'b1);
        chk("arst_occ", a.occupancy, 2'd0);
        sb.delete();
        prev_stall = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(0, 8'h00, 1);
            chk("post_rst_no_beat", a.out_valid, 1'b0);
        end
        step(1, 8'h33, 1);
        step(0, 8'h00, 1);
        chk("post_rst_new_beat", a.data_out, 8'h33);
        step(0, 8'h00, 1);
        chk("post_rst_sb_empty", sb.size(), 0);

        // Random valid/ready traffic with sequence-numbered payloads.
        acc = 0;
        cyc = 0;
        nxt = 8'h00;
        while (acc < 10000 && cyc < 40000) begin
            iv   = 1'($urandom_range(0, 1));
            ordy = 1'($urandom_range(0, 1));
            step(iv, nxt, ordy);
            if (a.in_valid && a.in_ready) begin
                acc++;
                nxt++;
            end
            cyc++;
        end
        chk("rand_accept_budget", (acc >= 10000), 1'b1);
        for (int i = 0; i < 8; i++) step(0, 8'h00, 1);
        chk("rand_drain", sb.size(), 0);
        chk("rand_drain_occ", a.occupancy, 2'd0);

        // Bypass build: outputs track inputs within the same cycle.
        for (int i = 0; i < 8; i++) begin
            iv   = 1'($urandom_range(0, 1));
            ordy = 1'(i % 2);
            d    = 8'($urandom_range(0, 255));
            @(negedge clk);
            b.in_valid  = iv;
            b.out_ready = ordy;
            b.data_in   = d;
            #1;
            chk("byp_out_valid", b.out_valid, iv);
            chk("byp_data", b.data_out, d);
            chk("byp_in_ready", b.in_ready, ordy);
            chk("byp_occ", b.occupancy, 2'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ehl_rv_skid.md
EHL_RV_SKID -- requirements
Module: ehl_rv_skid

Interface
REQ-001 Parameter ENA, default 1'b1, 1 inserts the registered skid slice; 0 selects pure combinational bypass.
REQ-002 Parameter WIDTH, default 8, payload width in bits; legal range 1..1024.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream beat valid.
REQ-006 in_ready  output  1  slice can accept a beat; driven directly from a flop when ENA=1.
REQ-007 data_in  input  WIDTH  upstream payload.
REQ-008 out_valid  output  1  downstream beat valid; driven directly from a flop when ENA=1.
REQ-009 out_ready  input  1  downstream accepts beat.
REQ-010 data_out  output  WIDTH  downstream payload; driven directly from the main data register when ENA=1.
REQ-011 occupancy  output  2  beats held: 0, 1 or 2.

Function
REQ-012 Transfer on either side SHALL occur only in a cycle where valid and ready are both high at the rising edge.
REQ-013 ENA=1: slice SHALL hold a main register (visible at data_out) and a skid register, and no output SHALL have a combinational path from any input.
REQ-014 FSM states: EMPTY (occ 0, in_ready=1, out_valid=0), BUSY (occ 1, in_ready=1, out_valid=1), FULL (occ 2, in_ready=0, out_valid=1).
REQ-015 EMPTY: in_valid -> main<=data_in, go BUSY; else stay.
REQ-016 BUSY: in_valid & out_ready -> main<=data_in, stay BUSY.
REQ-017 BUSY: in_valid & !out_ready -> skid<=data_in, main unchanged, go FULL.
REQ-018 BUSY: !in_valid & out_ready -> go EMPTY; !in_valid & !out_ready -> stay, main unchanged.
REQ-019 FULL: out_ready -> main<=skid, go BUSY; !out_ready -> stay, both registers unchanged; in_valid ignored (in_ready=0).
REQ-020 Latency SHALL be 1 cycle from input acceptance to out_valid when entering EMPTY->BUSY; sustained throughput SHALL be 1 beat/cycle with out_ready held high.
REQ-021 Beat order SHALL be preserved; no beat SHALL be dropped or duplicated under any valid/ready pattern.
REQ-022 data_out and out_valid SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 occupancy SHALL equal 0/1/2 for EMPTY/BUSY/FULL respectively, registered.
REQ-024 ENA=0: out_valid=in_valid, data_out=data_in, in_ready=out_ready, occupancy=0, no flops.
REQ-025 Data registers SHALL load only on the conditions above (no reset on data path); data_out is don't-care while out_valid=0.

Reset
REQ-026 reset_n low SHALL asynchronously force state EMPTY: out_valid=0, in_ready=1, occupancy=0.
REQ-027 Reset asserted in any state, including FULL, SHALL discard both held beats; no beat SHALL appear at the output after reset release until a new input acceptance.
REQ-028 First input acceptance SHALL be possible on the first rising edge after reset_n deasserts.

Verification
REQ-029 Reset, then in_valid=1 data_in=0x11 one cycle, out_ready=1 -> next cycle out_valid=1 data_out=0x11, following cycle out_valid=0, occupancy 1->0.
REQ-030 Stream 0x01..0x08 back-to-back, out_ready=1 constant -> outputs 0x01..0x08 on 8 consecutive cycles, in_ready never low.
REQ-031 BUSY holding 0xA0, out_ready=0, push 0xA1 -> in_ready=0, occupancy=2; raise out_ready -> 0xA0 then 0xA1 delivered in order, in_ready returns 1 after first pop.
REQ-032 Random in_valid/out_ready (50% each, 10k beats, scoreboard) -> zero loss/duplication/reorder, data_out stable under stall.
REQ-033 Reset pulse while FULL (0xB0,0xB1 held) -> out_valid=0, in_ready=1, occupancy=0 immediately; neither 0xB0 nor 0xB1 ever output.
REQ-034 ENA=0 build: toggle in_valid/out_ready/data_in -> outputs follow inputs in same cycle, occupancy=0.
